rr_grant_hold_ctrl: RTL and testbench
=====================================

Name: rr_grant_hold_ctrl

Overview:
Registered round-robin grant controller. It sits directly downstream of the thermometer priority-mask stage in the arbiter.
- Keeps its own thermometer priority mask register, selects one requester per arbitration, and issues a registered one-hot grant.
- Holds the grant until the owner drops its request or a hold-limit counter expires.
- Produces the grant vector, grant index and the live priority mask that the rest of the arbiter consumes.

Parameters:
request_lines, 4, number of requesters N (≥2).
MAX_HOLD, 8, maximum consecutive grant cycles per ownership; 0 = unlimited.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low; clears all state while low.
req  input  request_lines  request vector, bit i = requester i.
gnt  output  request_lines  registered one-hot grant; all zero when no owner.
gnt_id  output  $clog2(request_lines)  binary index of the current owner; 0 when gnt_valid=0.
gnt_valid  output  1  high while any grant is held (equals |gnt).
mask_q  output  request_lines  current thermometer priority mask; bit i=1 means requester i is in the high-priority group.

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_id=0, gnt_valid=0, mask_q=all ones, hold counter=0, state=IDLE.
- States: IDLE (no owner) and OWN (grant held). Counter width is $clog2(MAX_HOLD+1); with MAX_HOLD=0 the counter is unused.
- Selection in IDLE, combinational from req and mask_q:
  - m = req & mask_q; pick the lowest set index of m.
  - If m==0, pick the lowest set index of req.
  - If req==0, make no selection.
- IDLE -> OWN: at the first rising edge where req≠0.
  - gnt <= one-hot(k), gnt_id <= k, gnt_valid <= 1, counter <= 1.
  - mask_q <= bits strictly above k set, i.e. ~((1<<(k+1))-1), truncated to N bits. k=N-1 gives mask_q=0 (wrap: the next selection falls back to raw req, lowest index).
- Grant latency: req sampled at edge E in IDLE -> gnt visible after edge E, i.e. one cycle.
- OWN, each edge:
  - req[gnt_id]==0: release. gnt<=0, gnt_valid<=0, gnt_id<=0, counter<=0, -> IDLE.
  - else if MAX_HOLD≠0 and counter==MAX_HOLD: forced release with the same outputs, -> IDLE, even though req[gnt_id] is still high.
  - else: stay OWN, counter <= counter+1. gnt is held stable and changes in other req bits are ignored.
- Every release is followed by at least one IDLE cycle (gnt=0) before the next grant. There are no back-to-back grants.
- mask_q changes only at the IDLE->OWN edge and at reset; it is stable throughout OWN and IDLE.
- req changes during OWN never alter the owner, mask or counter, except the owner's own bit, which causes release.
- Simultaneous events:
  - Owner drops req on the same edge the counter hits MAX_HOLD: single release, no difference in result.
  - Reset asserted mid-OWN: outputs clear immediately, without waiting for clk.
  - Reset deasserted: the first possible grant is at the next rising edge with req≠0.
- Invariants (assertable):
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt == (gnt_valid ? 1<<gnt_id : 0).
  - In OWN, counter ≤ MAX_HOLD.
  - An owner is never granted in consecutive ownerships while another requester holding req continuously is waiting.

Test Plan:
1. Reset: N=4, drive rst=0 with req=4'b1111, then hold rst low 3 cycles -> gnt=0, gnt_id=0, gnt_valid=0, mask_q=4'b1111. Pulse rst low mid-OWN -> gnt=0 immediately, with no clock edge.
2. Fairness rotation: N=4, MAX_HOLD=3, req=4'b1111 constant -> owners 0,1,2,3,0. Each owner has gnt high for exactly 3 cycles followed by 1 idle cycle. mask_q takes the sequence 1110, 1100, 1000, 0000, 1110.
3. Single requester: req=4'b0100 from IDLE -> next cycle gnt=4'b0100, gnt_id=2, mask_q=4'b1000. Drop req[2] at edge t -> gnt=0 after edge t. Hold req=4'b0100 with MAX_HOLD=0 for 50 cycles -> grant held all 50 cycles.
4. Wrap-around: after owner 3 is released (mask_q=0000), req=4'b0011 -> grant 0, mask_q=4'b1110. Next req=4'b0011 -> grant 1.
5. Mask priority over lower index: after owner 1 (mask_q=1100), req=4'b1011 -> grant 3, not 0. Toggling req[0] while 3 owns leaves gnt=4'b1000 unchanged.
6. Forced release: MAX_HOLD=2, req=4'b0001 only, held high -> gnt pattern 1,1,0,1,1,0... with gnt_id=0 throughout.

Source files
------------

// File: rtl/rr_grant_hold_ctrl.sv
// Registered round-robin grant controller: thermometer-mask selection, one-hot
// grant held until the owner drops its request or the hold limit expires.
module rr_grant_hold_ctrl #(
  parameter int request_lines = 4,
  parameter int MAX_HOLD      = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [request_lines-1:0]         req,
  output logic [request_lines-1:0]         gnt,
  output logic [$clog2(request_lines)-1:0] gnt_id,
  output logic                             gnt_valid,
  output logic [request_lines-1:0]         mask_q
);

  localparam int N   = request_lines;
  localparam int IDW = $clog2(N);
  localparam int CW  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [N-1:0]     mask_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [N-1:0]     masked;
  logic             sel_found;
  logic [IDW-1:0]   sel_idx;
  logic             hold_expired;

  // Lowest raw request first, then overridden by the lowest masked request,
  // which is always a subset of the raw requests.
  always_comb begin
    masked    = req & mask_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) sel_idx = IDW'(i);
    end
  end

  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d        = S_OWN;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          id_d           = sel_idx;
          cnt_d          = CW'(1);
          for (int i = 0; i < N; i++) mask_d[i] = (i > int'(sel_idx));
        end
      end
      S_OWN: begin
        if (!req[id_q] || hold_expired) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          id_d    = '0;
          cnt_d   = '0;
        end else if (MAX_HOLD != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = (state_q == S_OWN);

endmodule

// File: tb/tb_rr_grant_hold_ctrl.sv
// Directed bench for rr_grant_hold_ctrl: three instances (hold limits 3, 0, 2)
// with a per-cycle expected queue drained by an independent monitor.
module tb_rr_grant_hold_ctrl;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int EW  = 2 + N + IDW + 1 + N;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_a, req_b, req_c;
  logic [N-1:0]   gnt_a, gnt_b, gnt_c;
  logic [IDW-1:0] id_a, id_b, id_c;
  logic           v_a, v_b, v_c;
  logic [N-1:0]   mask_a, mask_b, mask_c;

  logic [EW-1:0]  exp_q[$];
  int             tag_q[$];
  int             checks;
  int             errors;
  int             tno;
  event           async_chk;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_grant_hold_ctrl #(.request_lines(N), .MAX_HOLD(3)) u_h3 (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(id_a),
    .gnt_valid(v_a), .mask_q(mask_a)
  );
  rr_grant_hold_ctrl #(.request_lines(N), .MAX_HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(id_b),
    .gnt_valid(v_b), .mask_q(mask_b)
  );
  rr_grant_hold_ctrl #(.request_lines(N), .MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_id(id_c),
    .gnt_valid(v_c), .mask_q(mask_c)
  );

  // ---------------- driver tasks ----------------
  task automatic push_exp(input int sel, input logic [N-1:0] g, input logic [IDW-1:0] id,
                          input logic [N-1:0] m);
    exp_q.push_back({2'(sel), g, id, |g, m});
    tag_q.push_back(tno);
  endtask

  // Apply req to one instance, then queue the state expected after the next edge.
  task automatic step(input int sel, input logic [N-1:0] r, input logic [N-1:0] g,
                      input logic [IDW-1:0] id, input logic [N-1:0] m);
    case (sel)
      0:       req_a = r;
      1:       req_b = r;
      default: req_c = r;
    endcase
    @(posedge clk);
    #2;
    push_exp(sel, g, id, m);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    int            t;
    forever begin
      @(negedge clk or async_chk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        case (e[EW-1 -: 2])
          2'd0:    act = {2'd0, gnt_a, id_a, v_a, mask_a};
          2'd1:    act = {2'd1, gnt_b, id_b, v_b, mask_b};
          default: act = {2'd2, gnt_c, id_c, v_c, mask_c};
        endcase
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL test%0d dut%0d: got gnt=%b id=%0d valid=%b mask=%b, expected gnt=%b id=%0d valid=%b mask=%b",
                   t, e[EW-1 -: 2], act[EW-3 -: N], act[N+IDW : N+1], act[N], act[N-1:0],
                   e[EW-3 -: N], e[N+IDW : N+1], e[N], e[N-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] rot_mask [4];

  initial begin
    rot_mask = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    checks = 0;
    errors = 0;
    req_a  = '0;
    req_b  = '0;
    req_c  = '0;
    rst    = 1'b0;

    // 1: reset held with all requests active
    tno = 1;
    repeat (3) step(0, 4'b1111, 4'b0000, 2'd0, 4'b1111);
    rst = 1'b1;

    // 2: rotation with hold limit 3, three grant cycles then one idle cycle each
    tno = 2;
    for (int o = 0; o < 4; o++) begin
      repeat (3) step(0, 4'b1111, 4'(1 << o), 2'(o), rot_mask[o]);
      step(0, 4'b1111, 4'b0000, 2'd0, rot_mask[o]);
    end

    // 4: wrap-around from an empty mask
    tno = 4;
    step(0, 4'b0011, 4'b0001, 2'd0, 4'b1110);
    step(0, 4'b0010, 4'b0000, 2'd0, 4'b1110);
    step(0, 4'b0011, 4'b0010, 2'd1, 4'b1100);

    // 5: masked index beats lower index; non-owner toggles ignored
    tno = 5;
    step(0, 4'b0000, 4'b0000, 2'd0, 4'b1100);
    step(0, 4'b1011, 4'b1000, 2'd3, 4'b0000);
    step(0, 4'b1010, 4'b1000, 2'd3, 4'b0000);
    step(0, 4'b1011, 4'b1000, 2'd3, 4'b0000);
    step(0, 4'b1010, 4'b0000, 2'd0, 4'b0000);
    step(0, 4'b0000, 4'b0000, 2'd0, 4'b0000);

    // 1b: asynchronous reset while a grant is held
    tno = 6;
    step(0, 4'b0001, 4'b0001, 2'd0, 4'b1110);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    push_exp(0, 4'b0000, 2'd0, 4'b1111);
    -> async_chk;
    step(0, 4'b0000, 4'b0000, 2'd0, 4'b1111);
    rst = 1'b1;

    // 3: single requester, then release on drop
    tno = 3;
    step(0, 4'b0100, 4'b0100, 2'd2, 4'b1000);
    step(0, 4'b0000, 4'b0000, 2'd0, 4'b1000);

    // 3b: unlimited hold keeps the grant for 50 cycles
    tno = 7;
    repeat (50) step(1, 4'b0100, 4'b0100, 2'd2, 4'b1000);
    step(1, 4'b0000, 4'b0000, 2'd0, 4'b1000);

    // 6: forced release with hold limit 2 gives 1,1,0 repeating
    tno = 8;
    repeat (3) begin
      step(2, 4'b0001, 4'b0001, 2'd0, 4'b1110);
      step(2, 4'b0001, 4'b0001, 2'd0, 4'b1110);
      step(2, 4'b0001, 4'b0000, 2'd0, 4'b1110);
    end
    step(2, 4'b0000, 4'b0000, 2'd0, 4'b1110);

    // ---------------- final report ----------------
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
